// File: rtl/vga_overlay_pkg.sv
// Shared geometry constants and segment helpers for the VGA digit overlay.
package vga_overlay_pkg;

    localparam int DIGIT_W    = 5;
    localparam int DIGIT_H    = 9;
    localparam int DIGIT_GAP  = 3;
    localparam int PAIR_GAP   = 5;
    localparam int PAIR_PITCH = 2 * DIGIT_W + DIGIT_GAP + PAIR_GAP;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Corners (cols 0/4 on rows 0/4/8) belong to no segment, so they stay dark.
    function automatic logic seg_lit(
        input logic [6:0] seg,
        input logic [2:0] col,
        input logic [3:0] row
    );
        logic l;
        logic r;
        logic m;
        l = (col == 3'd0);
        r = (col == 3'd4);
        m = (col >= 3'd1) && (col <= 3'd3);
        seg_lit = 1'b0;
        unique case (row)
            4'd0:             seg_lit = m & seg[SEG_A];
            4'd1, 4'd2, 4'd3: seg_lit = (l & seg[SEG_F]) | (r & seg[SEG_B]);
            4'd4:             seg_lit = m & seg[SEG_G];
            4'd5, 4'd6, 4'd7: seg_lit = (l & seg[SEG_E]) | (r & seg[SEG_C]);
            4'd8:             seg_lit = m & seg[SEG_D];
            default:          seg_lit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vga_digit_overlay_seg7.sv
// BCD to seven-segment {a,b,c,d,e,f,g}; codes above 9 decode to all-off.
module seg7_decode (
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h00;
        unique case (bcd_i)
            4'd0:    seg_o = 7'h7E;
            4'd1:    seg_o = 7'h30;
            4'd2:    seg_o = 7'h6D;
            4'd3:    seg_o = 7'h79;
            4'd4:    seg_o = 7'h33;
            4'd5:    seg_o = 7'h5B;
            4'd6:    seg_o = 7'h5F;
            4'd7:    seg_o = 7'h70;
            4'd8:    seg_o = 7'h7F;
            4'd9:    seg_o = 7'h7B;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/vga_digit_overlay.sv
// Seven-segment clock overlay: sync-derived beam counters, per-frame input
// shadows, cursor blink and a two-stage pixel pipeline.
module vga_digit_overlay
    import vga_overlay_pkg::*;
#(
    parameter int         NUM_DIGITS   = 6,
    parameter int         SCALE_LOG2   = 0,
    parameter int         H_OFFSET     = 48,
    parameter int         V_OFFSET     = 33,
    parameter int         BLINK_FRAMES = 30,
    parameter logic [2:0] FG_RGB       = 3'b111,
    localparam int        SEL_W        = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    h_sinc,
    input  logic                    v_sinc,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [10:0]             x_pos,
    input  logic [10:0]             y_pos,
    input  logic                    blink_en,
    input  logic [SEL_W-1:0]        blink_sel,
    output logic                    Rout,
    output logic                    Gout,
    output logic                    Bout
);

    logic                    hs_q, vs_q;
    logic                    h_fall, v_fall;
    logic [10:0]             h_cnt_q, v_cnt_q;
    logic [4*NUM_DIGITS-1:0] dig_sh_q;
    logic [10:0]             x_sh_q, y_sh_q;
    logic                    ben_sh_q;
    logic [SEL_W-1:0]        bsel_sh_q;
    logic [7:0]              frame_q;
    logic                    phase_q;

    assign h_fall = hs_q & ~h_sinc;
    assign v_fall = vs_q & ~v_sinc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            dig_sh_q  <= {NUM_DIGITS{4'hF}};
            x_sh_q    <= '0;
            y_sh_q    <= '0;
            ben_sh_q  <= 1'b0;
            bsel_sh_q <= '0;
            frame_q   <= '0;
            phase_q   <= 1'b0;
        end else begin
            hs_q <= h_sinc;
            vs_q <= v_sinc;
            if (h_fall)
                h_cnt_q <= '0;
            else if (h_cnt_q != 11'h7FF)
                h_cnt_q <= h_cnt_q + 11'd1;
            if (v_fall)
                v_cnt_q <= '0;
            else if (h_fall)
                v_cnt_q <= v_cnt_q + 11'd1;
            if (v_fall) begin
                dig_sh_q  <= digits;
                x_sh_q    <= x_pos;
                y_sh_q    <= y_pos;
                ben_sh_q  <= blink_en;
                bsel_sh_q <= blink_sel;
                if (frame_q == 8'(BLINK_FRAMES - 1)) begin
                    frame_q <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    frame_q <= frame_q + 8'd1;
                end
            end
        end
    end

    logic [11:0] x_rel, y_rel;
    logic [10:0] cx, cy, pair, rem, idx;
    logic        left_hit, right_hit, on_d, blank;
    logic [2:0]  col_d;
    logic [3:0]  dig_d;

    // Bit 11 of the relative coordinate flags "left of / above" the overlay.
    assign x_rel = {1'b0, h_cnt_q} - 12'(H_OFFSET) - {1'b0, x_sh_q};
    assign y_rel = {1'b0, v_cnt_q} - 12'(V_OFFSET) - {1'b0, y_sh_q};
    assign cx    = x_rel[10:0] >> SCALE_LOG2;
    assign cy    = y_rel[10:0] >> SCALE_LOG2;
    assign pair  = cx / 11'(PAIR_PITCH);
    assign rem   = cx % 11'(PAIR_PITCH);

    assign left_hit  = rem < 11'(DIGIT_W);
    assign right_hit = (rem >= 11'(DIGIT_W + DIGIT_GAP)) &&
                       (rem < 11'(2 * DIGIT_W + DIGIT_GAP));
    assign idx   = (pair << 1) | {10'd0, right_hit};
    assign col_d = right_hit ? 3'(rem - 11'(DIGIT_W + DIGIT_GAP)) : 3'(rem);
    assign blank = ben_sh_q && phase_q && (idx == 11'(bsel_sh_q));
    assign on_d  = !x_rel[11] && !y_rel[11] &&
                   (cy < 11'(DIGIT_H)) &&
                   (pair < 11'(NUM_DIGITS / 2)) &&
                   (left_hit || right_hit);

    always_comb begin
        dig_d = 4'hF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 11'(i))
                dig_d = dig_sh_q[4*(NUM_DIGITS-1-i) +: 4];
        end
        if (blank)
            dig_d = 4'hF;
    end

    logic       s1_on_q;
    logic [2:0] s1_col_q;
    logic [3:0] s1_row_q;
    logic [3:0] s1_dig_q;
    logic [6:0] seg;
    logic [2:0] rgb_q;

    seg7_decode u_dec (
        .bcd_i (s1_dig_q),
        .seg_o (seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_on_q  <= 1'b0;
            s1_col_q <= '0;
            s1_row_q <= '0;
            s1_dig_q <= 4'hF;
            rgb_q    <= '0;
        end else begin
            s1_on_q  <= on_d;
            s1_col_q <= col_d;
            s1_row_q <= cy[3:0];
            s1_dig_q <= dig_d;
            rgb_q    <= (s1_on_q && seg_lit(seg, s1_col_q, s1_row_q)) ?
                        FG_RGB : 3'b000;
        end
    end

    assign {Rout, Gout, Bout} = rgb_q;

endmodule

// File: tb/tb_vga_digit_overlay.sv
// Scoreboard bench: a short-line raster with randomized frame inputs is
// compared pixel by pixel against a geometric model of the glyph row.
module tb_vga_digit_overlay;

    localparam int ND       = 6;
    localparam int SC       = 1;
    localparam int HO       = 8;
    localparam int VO       = 2;
    localparam int BF       = 2;
    localparam int LINE     = 132;
    localparam int HSW      = 4;
    localparam int FLINES   = 30;
    localparam int VSL      = 2;
    localparam int NDIR     = 7;
    localparam int NFR      = 11;
    localparam int SAT_LINE = 12;
    localparam int SAT_LEN  = 2300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        h_sinc = 1'b1;
    logic        v_sinc = 1'b1;
    logic [23:0] digits = 24'h888888;
    logic [10:0] x_pos = '0;
    logic [10:0] y_pos = '0;
    logic        blink_en = 1'b0;
    logic [2:0]  blink_sel = '0;
    logic        Rout, Gout, Bout;

    always #5 clk = ~clk;

    vga_digit_overlay #(
        .NUM_DIGITS   (ND),
        .SCALE_LOG2   (SC),
        .H_OFFSET     (HO),
        .V_OFFSET     (VO),
        .BLINK_FRAMES (BF),
        .FG_RGB       (3'b111)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .h_sinc    (h_sinc),
        .v_sinc    (v_sinc),
        .digits    (digits),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .blink_en  (blink_en),
        .blink_sel (blink_sel),
        .Rout      (Rout),
        .Gout      (Gout),
        .Bout      (Bout)
    );

    logic [2:0]  exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    // Model view of what the display latched at the last vsync.
    logic [23:0] m_dig;
    int          m_x, m_y, m_bsel, m_nvf;
    bit          m_ben, m_valid;

    function automatic logic [6:0] font(input int d);
        logic [6:0] t [10];
        t = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
              7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        return t[d];
    endfunction

    function automatic logic [2:0] model_rgb(input int h, input int v);
        int px, py, cx, cy, p, r, col, idx, dig;
        logic [6:0] s;
        bit lit;
        if (!m_valid) return 3'b000;
        px = h - HO - m_x;
        py = v - VO - m_y;
        if (px < 0 || py < 0) return 3'b000;
        cx = px / (1 << SC);
        cy = py / (1 << SC);
        if (cy > 8) return 3'b000;
        p = cx / 18;
        r = cx % 18;
        if (p >= ND / 2) return 3'b000;
        if (r <= 4) begin
            idx = 2 * p;
            col = r;
        end else if (r >= 8 && r <= 12) begin
            idx = 2 * p + 1;
            col = r - 8;
        end else begin
            return 3'b000;
        end
        if (m_ben && ((m_nvf / BF) % 2 == 1) && idx == m_bsel) return 3'b000;
        dig = int'(m_dig[4*(ND-1-idx) +: 4]);
        if (dig > 9) return 3'b000;
        s = font(dig);
        lit = (s[6] && cy == 0 && col inside {[1:3]}) ||
              (s[5] && cy inside {[1:3]} && col == 4) ||
              (s[4] && cy inside {[5:7]} && col == 4) ||
              (s[3] && cy == 8 && col inside {[1:3]}) ||
              (s[2] && cy inside {[5:7]} && col == 0) ||
              (s[1] && cy inside {[1:3]} && col == 0) ||
              (s[0] && cy == 4 && col inside {[1:3]});
        return lit ? 3'b111 : 3'b000;
    endfunction

    task automatic randomize_inputs();
        for (int i = 0; i < ND; i++)
            digits[4*i +: 4] = 4'($urandom_range(0, 15));
        x_pos     = 11'($urandom_range(0, 15));
        y_pos     = 11'($urandom_range(0, 7));
        blink_en  = 1'($urandom_range(0, 1));
        blink_sel = 3'($urandom_range(0, 7));
    endtask

    task automatic directed_inputs(input int f);
        blink_en  = 1'b0;
        blink_sel = 3'd0;
        unique case (f)
            0: begin digits = 24'h888888; x_pos = 11'd0; y_pos = 11'd0; end
            1: begin digits = 24'h000000; x_pos = 11'd3; y_pos = 11'd1; end
            2: begin digits = 24'h1C9876; x_pos = 11'd0; y_pos = 11'd0; end
            default: begin
                digits = 24'h123456; x_pos = 11'd5; y_pos = 11'd2;
                blink_en = 1'b1; blink_sel = 3'd3;
            end
        endcase
    endtask

    task automatic run_line(input int f, input int l, input int len,
                            input bit in_frame);
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            h_sinc = (k >= HSW);
            v_sinc = !(in_frame && l < VSL);
            if (in_frame && l == 0 && k == 0) begin
                if (f < NDIR) directed_inputs(f);
                m_dig   = digits;
                m_x     = int'(x_pos);
                m_y     = int'(y_pos);
                m_ben   = blink_en;
                m_bsel  = int'(blink_sel);
                m_nvf   = m_nvf + 1;
                m_valid = 1'b1;
            end
            if (l == 10 && k == 0) randomize_inputs();
            exp_q.push_back(model_rgb(k > 2047 ? 2047 : k, l));
        end
    endtask

    initial begin : monitor
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() >= 4) begin
                e = exp_q.pop_front();
                vectors++;
                if ({Rout, Gout, Bout} !== e) begin
                    miscompares++;
                    $display("FAIL pixel t=%0t got=%b want=%b",
                             $time, {Rout, Gout, Bout}, e);
                end
            end
        end
    end

    initial begin : stimulus
        m_valid = 1'b0;
        m_nvf   = 0;
        m_dig   = '1;
        m_x = 0; m_y = 0; m_bsel = 0; m_ben = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({Rout, Gout, Bout} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_rgb got=%b want=000", {Rout, Gout, Bout});
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Idle then one full raster with no vsync: shadows still blank.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            exp_q.push_back(model_rgb(0, 0));
        end
        for (int l = 0; l < FLINES; l++) run_line(0, l, LINE, 1'b0);
        for (int f = 0; f < NFR; f++) begin
            for (int l = 0; l < FLINES; l++) begin
                if (f == NFR - 1 && l == SAT_LINE) begin
                    run_line(f, l, SAT_LEN, 1'b1);
                    break;
                end
                run_line(f, l, LINE, 1'b1);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
